fifo_share_ctrl: RTL
====================

# fifo_share_ctrl

Shares one synchronous FIFO between `N_REQ` write requesters and a single consumer. A work-conserving round-robin arbiter grants the requesters, and the block drives the FIFO's write and read strobes. It keeps its own write-space and read-data counters, which compensate for the FIFO's registered full/empty flags (those lag the pointers by `FLAG_LAT` cycles). It sits directly between the requesters, the consumer and a `sync_fifo` instance of matching `DATA_WIDTH`/`DEPTH`. All of these share `clk` and `rst_n`.

## Interface
- `N_REQ`, 4: number of write requesters (2..8)
- `DATA_WIDTH`, 8: data width, equal to the FIFO's
- `DEPTH`, 16: FIFO depth, power of two, equal to the FIFO's
- `FLAG_LAT`, 2: cycles from a FIFO pointer update to its flag reflecting it
- `AFULL_THRESH`, 12: `almost_full` asserts when `level >= AFULL_THRESH`
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  `N_REQ`  per-requester valid; requester holds `req` and data until granted
- `req_data`  in  `N_REQ*DATA_WIDTH`  requester i data in bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `gnt`  out  `N_REQ`  combinational one-hot accept; transfer occurs at the edge where `req[i]&gnt[i]`
- `fifo_wr_en`  out  1  registered FIFO write strobe
- `fifo_data_in`  out  `DATA_WIDTH`  registered FIFO write data
- `fifo_rd_en`  out  1  combinational FIFO read strobe
- `fifo_data_out`  in  `DATA_WIDTH`  FIFO registered read data
- `fifo_full`, `fifo_empty`  in  1  FIFO flags; used only for error checking
- `pop`  in  1  consumer read request, level-sensitive
- `pop_valid`  out  1  registered; `pop_data` valid this cycle
- `pop_data`  out  `DATA_WIDTH`  pass-through of `fifo_data_out`
- `level`  out  `$clog2(DEPTH)+1`  reserved occupancy (`wcount`)
- `almost_full`  out  1  `wcount >= AFULL_THRESH`
- `ovf_err`  out  1  sticky protocol-violation flag

## Operation
- **Counters.** Both are `$clog2(DEPTH)+1` bits wide, saturate-free and never wrap by construction.
  - `wcount` is the space reservation.
    - +1 at the end of every grant cycle.
    - -1 at the end of cycle `r+FLAG_LAT`, for a `fifo_rd_en` high in cycle `r`.
  - `rcount` is the readable data.
    - +1 at the end of cycle `w+FLAG_LAT`, for a `fifo_wr_en` high in cycle `w`.
    - -1 at the end of every cycle with `fifo_rd_en` high.
  - Simultaneous +1 and -1 events on the same counter net to zero.
  - The delays are implemented as `FLAG_LAT`-deep shift pipes of the write and read strobes.
- **Grant.** Allowed in a cycle only when `wcount < DEPTH`. A pending decrement landing at the end of the same cycle is not counted. At most one grant per cycle.
- **Round robin.**
  - `rr_ptr` holds the index of the last grant; reset value is `N_REQ-1`.
  - Search starts at `rr_ptr+1` and wraps modulo `N_REQ`. The first asserted `req` wins.
  - `rr_ptr` updates only on a grant.
  - Non-requesting inputs are skipped, so no cycle idles while a request is pending and space exists.
- **Write path.** On a grant to i, at the next edge: `fifo_wr_en<=1`, `fifo_data_in<=req_data[i]`. Otherwise `fifo_wr_en<=0` and `fifo_data_in` holds its value.
- **Read path.**
  - `fifo_rd_en = pop & (rcount != 0)`.
  - `pop_valid <= fifo_rd_en`.
  - `pop_data = fifo_data_out`.
  - `pop` is a request, not a handshake: the consumer takes data only when `pop_valid` is high.
- **Error check.** `ovf_err` sets on `fifo_wr_en & fifo_full` or `fifo_rd_en & fifo_empty`. Once set it clears only on reset and must never assert in correct operation.
- **Reset (any time, including mid-transfer):**
  - Immediately clears `wcount`, `rcount`, both delay pipes, `fifo_wr_en`, `fifo_data_in`, `pop_valid` and `ovf_err`.
  - Sets `rr_ptr` to `N_REQ-1`.
  - Forces `gnt` and `fifo_rd_en` to 0 while `rst_n` is low.
  - Requests in flight are dropped. The FIFO resets on the same `rst_n`, so the counters and the FIFO contents agree.

## Timing
- Reset values: `gnt=0`, `fifo_wr_en=0`, `fifo_data_in=0`, `fifo_rd_en=0`, `pop_valid=0`, `level=0`, `almost_full=0`, `ovf_err=0`. `pop_data` follows `fifo_data_out`, which is 0 during reset.
- **Grant to write.** Grant in cycle c gives `fifo_wr_en` high in cycle c+1.
- **Write to readable.** A write in cycle w can produce `fifo_rd_en` no earlier than cycle `w+FLAG_LAT+1`.
- **Pop latency.** `fifo_rd_en` in cycle r gives `pop_valid` in cycle r+1.
- **Full-FIFO restart.** A read in cycle r frees space for a grant no earlier than cycle `r+FLAG_LAT+1`.
- **Throughput.** Steady state is 1 write/cycle while `wcount < DEPTH` and 1 read/cycle while `rcount > 0`.

## Test plan
- **Round robin from reset.** Release reset with `req=4'b1111` held and data `0x10+i` → `gnt` one-hot 0,1,2,3,0 on consecutive cycles; `fifo_data_in` shows 0x10, 0x11, 0x12, 0x13 one cycle after each grant.
- **Fill.** `req=4'b0001`, `pop=0` → exactly 16 grants, then `gnt=0`; `level=16`; `almost_full` rises at the end of the 12th grant cycle; `ovf_err` stays 0.
- **Single-entry latency.** Write 0xA5 granted in cycle c with `pop` held → `fifo_wr_en` in c+1, `fifo_rd_en` first in c+4, `pop_valid` in c+5 with `pop_data=0xA5`.
- **Drain at full.** Raise `pop` with `level=16` and `req0` still asserted → first `fifo_rd_en` in cycle r, next grant in r+3, no dropped or duplicated data over 64 transfers, `ovf_err=0`.
- **Skip idle requesters.** `req=4'b1010` → grants 1,3,1,3; then drop `req[1]` → only 3 is granted, every cycle.
- **Reset mid-operation.** Drive reset low at `level=7` with `fifo_wr_en` high → all outputs 0 immediately. After release with `req=4'b1111`, the first grant goes to requester 0 and `level` restarts from 0.

Source files
------------

// File: rtl/fifo_share_ctrl.sv
// Round-robin write arbiter and read controller in front of a shared sync FIFO.
// Private counters hide the FIFO's lagging full/empty flags from the datapath.
module fifo_share_ctrl #(
  parameter int N_REQ        = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int FLAG_LAT     = 2,
  parameter int AFULL_THRESH = 12
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [N_REQ-1:0]              gnt,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic                          fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]         fifo_data_out,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  input  logic                          pop,
  output logic                          pop_valid,
  output logic [DATA_WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          almost_full,
  output logic                          ovf_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [CW-1:0]         r_wcount;
  logic [CW-1:0]         r_rcount;
  logic [FLAG_LAT-1:0]   r_wr_pipe;
  logic [FLAG_LAT-1:0]   r_rd_pipe;
  logic [PW-1:0]         r_rr_ptr;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_data_in;
  logic                  r_pop_valid;
  logic                  r_ovf;

  logic                  w_space;
  logic                  w_gnt_any;
  logic [PW-1:0]         w_gnt_idx;
  logic [N_REQ-1:0]      w_gnt;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_rd_en;
  logic                  w_wr_land;
  logic                  w_rd_land;

  function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base,
                                          input int k);
    rr_idx = PW'((int'(base) + k) % N_REQ);
  endfunction

  assign w_space   = r_wcount < CW'(DEPTH);
  assign w_wr_land = r_wr_pipe[FLAG_LAT-1];
  assign w_rd_land = r_rd_pipe[FLAG_LAT-1];
  assign w_rd_en   = rst_n & pop & (r_rcount != '0);

  // Search begins just past the last winner so idle inputs cost nothing.
  always_comb begin
    w_gnt     = '0;
    w_gnt_any = 1'b0;
    w_gnt_idx = r_rr_ptr;
    if (rst_n && w_space) begin
      for (int k = 1; k <= N_REQ; k++) begin
        if (!w_gnt_any && req[rr_idx(r_rr_ptr, k)]) begin
          w_gnt_any = 1'b1;
          w_gnt_idx = rr_idx(r_rr_ptr, k);
        end
      end
    end
    if (w_gnt_any) w_gnt[w_gnt_idx] = 1'b1;
  end

  always_comb begin
    w_sel_data = req_data[int'(w_gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr  <= PW'(N_REQ - 1);
      r_wr_en   <= 1'b0;
      r_data_in <= '0;
    end else begin
      r_wr_en <= w_gnt_any;
      if (w_gnt_any) begin
        r_rr_ptr  <= w_gnt_idx;
        r_data_in <= w_sel_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_pipe <= '0;
      r_rd_pipe <= '0;
    end else begin
      r_wr_pipe[0] <= r_wr_en;
      r_rd_pipe[0] <= w_rd_en;
      for (int k = 1; k < FLAG_LAT; k++) begin
        r_wr_pipe[k] <= r_wr_pipe[k-1];
        r_rd_pipe[k] <= r_rd_pipe[k-1];
      end
    end
  end

  // Space is released only once the FIFO's full flag has caught up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcount <= '0;
    end else begin
      unique case ({w_gnt_any, w_rd_land})
        2'b10:   r_wcount <= r_wcount + 1'b1;
        2'b01:   r_wcount <= r_wcount - 1'b1;
        default: r_wcount <= r_wcount;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rcount <= '0;
    end else begin
      unique case ({w_wr_land, w_rd_en})
        2'b10:   r_rcount <= r_rcount + 1'b1;
        2'b01:   r_rcount <= r_rcount - 1'b1;
        default: r_rcount <= r_rcount;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_valid <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_pop_valid <= w_rd_en;
      if ((r_wr_en && fifo_full) || (w_rd_en && fifo_empty)) r_ovf <= 1'b1;
    end
  end

  assign gnt          = w_gnt;
  assign fifo_wr_en   = r_wr_en;
  assign fifo_data_in = r_data_in;
  assign fifo_rd_en   = w_rd_en;
  assign pop_valid    = r_pop_valid;
  assign pop_data     = fifo_data_out;
  assign level        = r_wcount;
  assign almost_full  = r_wcount >= CW'(AFULL_THRESH);
  assign ovf_err      = r_ovf;

endmodule
